bit_serial_adder: RTL and testbench

- Adds two WIDTH-bit operands plus a carry-in, one bit per clock, LSB first.
- Built around a single `structuralFullAdder` cell. A carry flip-flop closes the loop, so the carry from bit i feeds bit i+1.
- Sits downstream of the full-adder cell and consumes its sum/carryout every cycle. This is the area-minimal alternative to a WIDTH-cell ripple adder.
- A start/busy/done handshake lets a controller launch an addition and collect a registered result.

---
 rtl/bit_serial_adder.sv | 146 ++++++++++++++
 tb/tb_bit_serial_adder.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one structuralFullAdder cell plus a carry flip-flop, LSB first,
// with a start/busy/done handshake and registered sum/carryout/overflow.

module structuralFullAdder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_carryin,
  output logic o_sum,
  output logic o_carryout
);
  logic w_ab_xor;
  logic w_ab_and;
  logic w_cx_and;

  assign w_ab_xor   = i_a ^ i_b;
  assign w_ab_and   = i_a & i_b;
  assign w_cx_and   = w_ab_xor & i_carryin;
  assign o_sum      = w_ab_xor ^ i_carryin;
  assign o_carryout = w_ab_and | w_cx_and;
endmodule

module bit_serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_carryin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carryout,
  output logic             o_overflow
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] w_work_next;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_carryout;
  logic             r_overflow;
  logic             w_fa_sum;
  logic             w_fa_cout;
  logic             w_accept;
  logic             w_last;

  structuralFullAdder u_fa (
    .i_a        (r_a_sr[0]),
    .i_b        (r_b_sr[0]),
    .i_carryin  (r_carry),
    .o_sum      (w_fa_sum),
    .o_carryout (w_fa_cout)
  );

  // New sum bit enters at the MSB so the word is LSB-aligned after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_w1
      assign w_work_next = w_fa_sum;
    end else begin : g_wn
      assign w_work_next = {w_fa_sum, r_work[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_accept     = 1'b1;
          w_state_next = S_ADD;
        end
      end
      S_ADD: begin
        w_last = (r_cnt == CW'(WIDTH - 1));
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_a_sr     <= '0;
      r_b_sr     <= '0;
      r_work     <= '0;
      r_cnt      <= '0;
      r_carry    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_sum      <= '0;
      r_carryout <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_busy <= (w_state_next != S_IDLE);
      r_done <= (w_state_next == S_DONE);
      if (w_accept) begin
        r_a_sr  <= i_a;
        r_b_sr  <= i_b;
        r_carry <= i_carryin;
        r_work  <= '0;
        r_cnt   <= '0;
      end else if (r_state == S_ADD) begin
        r_a_sr  <= r_a_sr >> 1;
        r_b_sr  <= r_b_sr >> 1;
        r_carry <= w_fa_cout;
        r_work  <= w_work_next;
        r_cnt   <= r_cnt + CW'(1);
        if (w_last) begin
          r_sum      <= w_work_next;
          r_carryout <= w_fa_cout;
          r_overflow <= r_carry ^ w_fa_cout;
        end
      end
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_sum      = r_sum;
  assign o_carryout = r_carryout;
  assign o_overflow = r_overflow;
endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed bench for bit_serial_adder: an 8-bit instance for handshake/corner cases
// and a 4-bit instance swept over every (a,b,cin) combination.

module tb_bit_serial_adder;
  logic       clk = 1'b0;
  logic       rst;
  logic       start8, cin8, busy8, done8, co8, ov8;
  logic [7:0] a8, b8, sum8;
  logic       start4, cin4, busy4, done4, co4, ov4;
  logic [3:0] a4, b4, sum4;

  int n_checks = 0;
  int n_errors = 0;

  always #100 clk = ~clk;

  bit_serial_adder #(.WIDTH(8)) u_dut8 (
    .i_clk(clk), .i_reset(rst), .i_start(start8), .i_a(a8), .i_b(b8),
    .i_carryin(cin8), .o_busy(busy8), .o_done(done8), .o_sum(sum8),
    .o_carryout(co8), .o_overflow(ov8)
  );

  bit_serial_adder #(.WIDTH(4)) u_dut4 (
    .i_clk(clk), .i_reset(rst), .i_start(start4), .i_a(a4), .i_b(b4),
    .i_carryin(cin4), .o_busy(busy4), .o_done(done4), .o_sum(sum4),
    .o_carryout(co4), .o_overflow(ov4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Launches one 8-bit add from IDLE and watches it to completion. Optionally
  // re-asserts start with other operands at cycle re_k after the accepting edge.
  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic cin, input logic [7:0] exp_sum, input logic exp_co,
                      input logic exp_ov, input int re_k);
    int lat, bcnt, dcnt;
    logic [7:0] s;
    logic c, v;
    bit finished;
    lat = -1; bcnt = 0; dcnt = 0; s = '0; c = 1'b0; v = 1'b0; finished = 0;
    @(negedge clk);
    a8 = a; b8 = b; cin8 = cin; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (k == re_k) begin
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
      if (busy8) bcnt++;
      if (done8) begin
        dcnt++; lat = k; s = sum8; c = co8; v = ov8;
      end
      if (!busy8) begin
        finished = 1;
        break;
      end
      @(negedge clk);
    end
    start8 = 1'b0;
    check({tag, " finished"}, 32'(finished), 32'd1);
    check({tag, " sum"}, 32'(s), 32'(exp_sum));
    check({tag, " carryout"}, 32'(c), 32'(exp_co));
    check({tag, " overflow"}, 32'(v), 32'(exp_ov));
    check({tag, " done pulses"}, 32'(dcnt), 32'd1);
    check({tag, " done latency"}, 32'(lat), 32'd8);
    check({tag, " busy cycles"}, 32'(bcnt), 32'd9);
  endtask

  initial begin
    int dcnt, bcnt;
    logic [4:0] exp5;
    logic exp_ov4;
    bit seen;

    rst = 1'b1; start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("reset busy", 32'(busy8), 32'd0);
    check("reset done", 32'(done8), 32'd0);
    check("reset sum", 32'(sum8), 32'd0);
    check("reset carryout", 32'(co8), 32'd0);
    check("reset overflow", 32'(ov8), 32'd0);
    rst = 1'b0; start8 = 1'b0;
    @(negedge clk); @(negedge clk);
    check("post-reset idle busy", 32'(busy8), 32'd0);

    run8("basic", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0, -1);
    check("hold sum in idle", 32'(sum8), 32'h4B);
    run8("ff+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, -1);
    run8("7f+00+1", 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, -1);
    run8("80+80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, -1);
    run8("start while busy", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 2);
    dcnt = 0; bcnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done8) dcnt++;
      if (busy8) bcnt++;
    end
    check("no queued start done", 32'(dcnt), 32'd0);
    check("no queued start busy", 32'(bcnt), 32'd0);

    run8("pre-reset add", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0, -1);
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    for (int k = 0; k < 3; k++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid reset busy", 32'(busy8), 32'd0);
    check("mid reset sum", 32'(sum8), 32'd0);
    check("mid reset carryout", 32'(co8), 32'd0);
    check("mid reset overflow", 32'(ov8), 32'd0);
    rst = 1'b0;
    dcnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done8 || busy8) dcnt++;
    end
    check("mid reset no done", 32'(dcnt), 32'd0);

    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      a4 = 4'(i >> 5); b4 = 4'(i >> 1); cin4 = i[0]; start4 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start4 = 1'b0;
      exp5    = {1'b0, a4} + {1'b0, b4} + {4'b0, cin4};
      exp_ov4 = (a4[3] == b4[3]) && (exp5[3] != a4[3]);
      seen = 0;
      for (int k = 0; k < 10; k++) begin
        if (done4) begin
          seen = 1;
          check("w4 sum", 32'(sum4), 32'(exp5[3:0]));
          check("w4 carryout", 32'(co4), 32'(exp5[4]));
          check("w4 overflow", 32'(ov4), 32'(exp_ov4));
          break;
        end
        @(negedge clk);
      end
      check("w4 done seen", 32'(seen), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
